// File: rtl/key_sweep_controller.sv
// rtl/key_sweep_controller.sv - key/pattern sweep sequencer for a locked-circuit miter
module key_sweep_controller #(
    parameter int NUM_INPUTS = 5,
    parameter int KEY_WIDTH  = 2
) (
    input  logic                  C,
    input  logic                  R,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  match_in,
    output logic [NUM_INPUTS-1:0] pattern_out,
    output logic [KEY_WIDTH-1:0]  key_out,
    output logic                  busy,
    output logic                  done,
    output logic                  found,
    output logic [KEY_WIDTH:0]    keys_tried
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SWEEP = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [NUM_INPUTS-1:0] PAT_MAX = '1;
    localparam logic [NUM_INPUTS-1:0] PAT_ONE = NUM_INPUTS'(1);
    localparam logic [KEY_WIDTH-1:0]  KEY_MAX = '1;
    localparam logic [KEY_WIDTH-1:0]  KEY_ONE = KEY_WIDTH'(1);
    localparam logic [KEY_WIDTH:0]    KT_ONE  = (KEY_WIDTH + 1)'(1);

    logic [1:0]            state_q, state_d;
    logic [NUM_INPUTS-1:0] pattern_q, pattern_d;
    logic [KEY_WIDTH-1:0]  key_q, key_d;
    logic                  found_q, found_d;
    logic [KEY_WIDTH:0]    keys_tried_q, keys_tried_d;
    logic                  busy_q, done_q;

    // Next-state: one (key, pattern) pair judged per SWEEP cycle; abort wins over match.
    always_comb begin
        state_d      = state_q;
        pattern_d    = pattern_q;
        key_d        = key_q;
        found_d      = found_q;
        keys_tried_d = keys_tried_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_SWEEP;
                    pattern_d    = '0;
                    key_d        = '0;
                    found_d      = 1'b0;
                    keys_tried_d = KT_ONE;
                end
            end
            ST_SWEEP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    found_d = 1'b0;
                end else if (match_in) begin
                    if (pattern_q != PAT_MAX) begin
                        pattern_d = pattern_q + PAT_ONE;
                    end else begin
                        found_d = 1'b1;
                        state_d = ST_DONE;
                    end
                end else if (key_q != KEY_MAX) begin
                    key_d        = key_q + KEY_ONE;
                    pattern_d    = '0;
                    keys_tried_d = keys_tried_q + KT_ONE;
                end else begin
                    found_d = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; busy/done are registered decodes of the next state.
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            state_q      <= ST_IDLE;
            pattern_q    <= '0;
            key_q        <= '0;
            found_q      <= 1'b0;
            keys_tried_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pattern_q    <= pattern_d;
            key_q        <= key_d;
            found_q      <= found_d;
            keys_tried_q <= keys_tried_d;
            busy_q       <= (state_d == ST_SWEEP);
            done_q       <= (state_d == ST_DONE);
        end
    end

    assign pattern_out = pattern_q;
    assign key_out     = key_q;
    assign found       = found_q;
    assign keys_tried  = keys_tried_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
